// File: rtl/scan_hex.sv
// Command-line scanner: returns one raw byte or a hex number of up to DIGITS digits
// from the UART receive stream, with backspace editing and error flagging.
module scan_hex #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned AUTO_END = 1,
  parameter int unsigned CW       = $clog2(DIGITS + 1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [7:0]            d_rx,
  input  logic                  vld_rx,
  output logic                  rdy_rx,
  input  logic                  req_rx,
  input  logic                  type_rx,
  output logic                  ack_rx,
  output logic [4*DIGITS-1:0]   din_rx,
  output logic [CW-1:0]         cnt_rx,
  output logic                  flag_rx,
  output logic                  err_rx
);

  localparam int unsigned     W       = 4 * DIGITS;
  localparam logic [CW-1:0]   CNT_MAX = CW'(DIGITS);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    din_q, din_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            flag_q, flag_d;
  logic            err_q, err_d;
  logic            ack_q, ack_d;
  logic            rdy_q, rdy_d;
  logic            armed_q, armed_d;
  logic            accept;
  logic            complete;
  logic            is_hex;
  logic [3:0]      nib;

  // armed blocks a held character from being taken a second time
  assign accept  = (state_q == COLLECT) && vld_rx && !rdy_q && armed_q;
  assign rdy_d   = accept;
  assign armed_d = accept ? 1'b0 : (!vld_rx ? 1'b1 : armed_q);
  assign ack_d   = (state_d == DONE);

  always_comb begin
    is_hex = 1'b1;
    nib    = '0;
    if (d_rx >= 8'h30 && d_rx <= 8'h39)      nib = d_rx[3:0];
    else if (d_rx >= 8'h41 && d_rx <= 8'h46) nib = d_rx[3:0] + 4'd9;
    else if (d_rx >= 8'h61 && d_rx <= 8'h66) nib = d_rx[3:0] + 4'd9;
    else                                     is_hex = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_rx && !ack_q) state_d = COLLECT;
      COLLECT: if (!req_rx)          state_d = IDLE;
               else if (complete)    state_d = DONE;
      DONE:    if (!req_rx)          state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    din_d    = din_q;
    cnt_d    = cnt_q;
    flag_d   = flag_q;
    err_d    = err_q;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_rx && !ack_q) begin
          din_d  = '0;
          cnt_d  = '0;
          flag_d = 1'b0;
          err_d  = 1'b0;
        end
      end
      COLLECT: begin
        // an aborting request discards the character's effect; only rdy is kept
        if (accept && req_rx) begin
          if (!type_rx) begin
            din_d    = W'(d_rx);
            cnt_d    = '0;
            flag_d   = (d_rx == 8'h0D);
            complete = 1'b1;
          end else if (is_hex) begin
            if (cnt_q < CNT_MAX) begin
              din_d = (din_q << 4) | W'(nib);
              cnt_d = cnt_q + CW'(1);
              if (AUTO_END != 0 && (cnt_q + CW'(1)) == CNT_MAX) complete = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            case (d_rx)
              8'h08: begin
                if (cnt_q != '0) begin
                  din_d = din_q >> 4;
                  cnt_d = cnt_q - CW'(1);
                end
              end
              8'h20:   if (cnt_q != '0) complete = 1'b1;
              8'h0D: begin
                complete = 1'b1;
                flag_d   = (cnt_q == '0);
              end
              8'h0A:   ;
              default: err_d = 1'b1;
            endcase
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      din_q   <= '0;
      cnt_q   <= '0;
      flag_q  <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdy_q   <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      din_q   <= din_d;
      cnt_q   <= cnt_d;
      flag_q  <= flag_d;
      err_q   <= err_d;
      ack_q   <= ack_d;
      rdy_q   <= rdy_d;
      armed_q <= armed_d;
    end
  end

  assign rdy_rx  = rdy_q;
  assign ack_rx  = ack_q;
  assign din_rx  = din_q;
  assign cnt_rx  = cnt_q;
  assign flag_rx = flag_q;
  assign err_rx  = err_q;

endmodule

// File: tb/tb_scan_hex.sv
// Directed bench for scan_hex: default build (8 digits, auto-end) and a
// 2-digit terminator-only build share the character stream.
module tb_scan_hex;

  logic        clk, rstn;
  logic [7:0]  d_rx;
  logic        vld_rx, req, type_rx, sel;

  logic        rdy1, ack1, flag1, err1;
  logic [31:0] din1;
  logic [3:0]  cnt1;
  logic        rdy2, ack2, flag2, err2;
  logic [7:0]  din2;
  logic [1:0]  cnt2;

  logic        rdy_m, ack_m, flag_m, err_m;
  logic [31:0] din_m;
  logic [3:0]  cnt_m;

  int n_cmp = 0;
  int n_err = 0;
  int rdy_cnt = 0;
  logic rdy_prev = 1'b0;
  logic dbl = 1'b0;

  scan_hex #(.DIGITS(8), .AUTO_END(1)) u_dut8 (
    .clk(clk), .rstn(rstn), .d_rx(d_rx), .vld_rx(vld_rx), .rdy_rx(rdy1),
    .req_rx(req && !sel), .type_rx(type_rx), .ack_rx(ack1), .din_rx(din1),
    .cnt_rx(cnt1), .flag_rx(flag1), .err_rx(err1));

  scan_hex #(.DIGITS(2), .AUTO_END(0)) u_dut2 (
    .clk(clk), .rstn(rstn), .d_rx(d_rx), .vld_rx(vld_rx), .rdy_rx(rdy2),
    .req_rx(req && sel), .type_rx(type_rx), .ack_rx(ack2), .din_rx(din2),
    .cnt_rx(cnt2), .flag_rx(flag2), .err_rx(err2));

  assign rdy_m  = sel ? rdy2  : rdy1;
  assign ack_m  = sel ? ack2  : ack1;
  assign flag_m = sel ? flag2 : flag1;
  assign err_m  = sel ? err2  : err1;
  assign din_m  = sel ? {24'b0, din2} : din1;
  assign cnt_m  = sel ? {2'b0, cnt2}  : cnt1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rdy_m) rdy_cnt++;
    if (rdy_m && rdy_prev) dbl = 1'b1;
    rdy_prev = rdy_m;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send_char(input logic [7:0] c, output logic ack_seen);
    logic ok;
    @(negedge clk);
    d_rx = c;
    vld_rx = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (rdy_m) ok = 1'b1;
    end
    if (!ok) check_eq("rdy_timeout", 32'd0, 32'd1);
    ack_seen = ack_m;
    @(negedge clk);
    vld_rx = 1'b0;
    @(posedge clk);
  endtask

  task automatic send_str(input string s, output logic last_ack);
    last_ack = 1'b0;
    for (int i = 0; i < s.len(); i++) send_char(s[i], last_ack);
  endtask

  task automatic start_req(input logic t);
    @(negedge clk);
    type_rx = t;
    req = 1'b1;
    @(posedge clk);
  endtask

  task automatic end_req();
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    check_eq("ack_fall", {31'b0, ack_m}, 32'd0);
  endtask

  initial begin
    logic a;
    int r0;
    sel = 1'b0; rstn = 1'b0; req = 1'b0; vld_rx = 1'b0; type_rx = 1'b0; d_rx = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rdy",  {31'b0, rdy_m},  32'd0);
    check_eq("rst_ack",  {31'b0, ack_m},  32'd0);
    check_eq("rst_din",  din_m,           32'd0);
    check_eq("rst_cnt",  {28'b0, cnt_m},  32'd0);
    check_eq("rst_flag", {31'b0, flag_m}, 32'd0);
    check_eq("rst_err",  {31'b0, err_m},  32'd0);
    @(negedge clk) rstn = 1'b1;

    // reset in the middle of a line
    start_req(1'b1);
    send_str("12", a);
    check_eq("pre_rst_din", din_m, 32'h12);
    @(negedge clk) rstn = 1'b0;
    @(posedge clk);
    #1;
    check_eq("mid_rst_din", din_m, 32'd0);
    check_eq("mid_rst_cnt", {28'b0, cnt_m}, 32'd0);
    check_eq("mid_rst_ack", {31'b0, ack_m}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    req = 1'b0;
    @(posedge clk);
    start_req(1'b1);
    send_str("5", a);
    send_char(8'h0D, a);
    check_eq("r5_ack", {31'b0, a}, 32'd1);
    check_eq("r5_din", din_m, 32'h5);
    check_eq("r5_cnt", {28'b0, cnt_m}, 32'd1);
    end_req();

    // leading blanks, mixed case, CR terminator
    r0 = rdy_cnt;
    start_req(1'b1);
    send_str("  1a2B", a);
    check_eq("h1_ack_early", {31'b0, a}, 32'd0);
    send_char(8'h0D, a);
    check_eq("h1_ack",  {31'b0, a},      32'd1);
    check_eq("h1_din",  din_m,           32'h1A2B);
    check_eq("h1_cnt",  {28'b0, cnt_m},  32'd4);
    check_eq("h1_flag", {31'b0, flag_m}, 32'd0);
    check_eq("h1_err",  {31'b0, err_m},  32'd0);
    check_eq("h1_rdys", rdy_cnt - r0,    32'd7);
    end_req();
    check_eq("h1_hold", din_m, 32'h1A2B);

    // full width completes on its own
    start_req(1'b1);
    send_str("DEADBEE", a);
    check_eq("h2_ack_early", {31'b0, a}, 32'd0);
    send_char("F", a);
    check_eq("h2_ack", {31'b0, a}, 32'd1);
    check_eq("h2_din", din_m, 32'hDEADBEEF);
    check_eq("h2_cnt", {28'b0, cnt_m}, 32'd8);
    r0 = rdy_cnt;
    @(negedge clk);
    d_rx = "A";
    vld_rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("h2_no9th", rdy_cnt - r0, 32'd0);
    check_eq("h2_din_frozen", din_m, 32'hDEADBEEF);
    @(negedge clk) vld_rx = 1'b0;
    end_req();

    // empty line and raw bytes
    start_req(1'b1);
    send_char(8'h0D, a);
    check_eq("cr_ack",  {31'b0, a},      32'd1);
    check_eq("cr_flag", {31'b0, flag_m}, 32'd1);
    check_eq("cr_din",  din_m,           32'd0);
    check_eq("cr_cnt",  {28'b0, cnt_m},  32'd0);
    end_req();
    start_req(1'b0);
    send_char("A", a);
    check_eq("bA_ack",  {31'b0, a},      32'd1);
    check_eq("bA_din",  din_m,           32'h41);
    check_eq("bA_flag", {31'b0, flag_m}, 32'd0);
    end_req();
    start_req(1'b0);
    send_char(8'h0D, a);
    check_eq("bCR_din",  din_m,           32'h0D);
    check_eq("bCR_flag", {31'b0, flag_m}, 32'd1);
    check_eq("bCR_cnt",  {28'b0, cnt_m},  32'd0);
    end_req();

    // backspace, invalid char, space terminator
    start_req(1'b1);
    send_str("12", a);
    send_char(8'h08, a);
    send_str("3G4 ", a);
    check_eq("bs_ack", {31'b0, a},     32'd1);
    check_eq("bs_din", din_m,          32'h134);
    check_eq("bs_cnt", {28'b0, cnt_m}, 32'd3);
    check_eq("bs_err", {31'b0, err_m}, 32'd1);
    end_req();

    // digit overflow without auto-end
    sel = 1'b1;
    start_req(1'b1);
    send_str("ABC", a);
    check_eq("ov_ack_early", {31'b0, a}, 32'd0);
    send_char(8'h0D, a);
    check_eq("ov_ack",  {31'b0, a},      32'd1);
    check_eq("ov_din",  din_m,           32'hAB);
    check_eq("ov_cnt",  {28'b0, cnt_m},  32'd2);
    check_eq("ov_err",  {31'b0, err_m},  32'd1);
    check_eq("ov_flag", {31'b0, flag_m}, 32'd0);
    end_req();
    sel = 1'b0;

    // abort, idle with data pending, fresh request
    start_req(1'b1);
    send_str("12", a);
    @(negedge clk) req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("ab_ack", {31'b0, ack_m}, 32'd0);
    r0 = rdy_cnt;
    @(negedge clk);
    d_rx = "9";
    vld_rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("idle_no_rdy", rdy_cnt - r0, 32'd0);
    check_eq("idle_no_ack", {31'b0, ack_m}, 32'd0);
    @(negedge clk) vld_rx = 1'b0;
    @(posedge clk);
    start_req(1'b1);
    send_str("7 ", a);
    check_eq("r7_ack", {31'b0, a},     32'd1);
    check_eq("r7_din", din_m,          32'h7);
    check_eq("r7_cnt", {28'b0, cnt_m}, 32'd1);
    check_eq("r7_err", {31'b0, err_m}, 32'd0);
    end_req();

    check_eq("rdy_back2back", {31'b0, dbl}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
